stream_tap_arb: RTL and testbench

- Round-robin arbiter that merges the tapped outputs of N stream_tap instances into one shared consumer, such as a shared monitor, checksum or debug sink.
- Each tap emits every value TAP_REP times, so the arbiter holds a grant for exactly TAP_REP accepted beats. A repetition group is never interleaved with another source.
- Output is a single registered stage with full throughput and no bubble between groups.

---
 rtl/stream_tap_arb.sv | 153 +++++++++++++++
 tb/tb_stream_tap_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_tap_arb.sv
// Round-robin merge of N stream_tap outputs, holding each grant for TAP_REP accepted beats.
// Optional macro STREAM_TAP_ARB_LAST_EN adds a registered olast port marking the final beat of a group.
module stream_tap_arb #(
    parameter  int N_TAPS     = 2,
    parameter  int DATA_WIDTH = 8,
    parameter  int TAP_REP    = 1,
    localparam int SEL_BITS   = $clog2(N_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_TAPS*DATA_WIDTH-1:0] idat,
    input  logic [N_TAPS-1:0]            ivld,
    output logic [N_TAPS-1:0]            irdy,
    output logic [DATA_WIDTH-1:0]        odat,
    output logic [SEL_BITS-1:0]          osel,
    output logic                         ovld,
`ifdef STREAM_TAP_ARB_LAST_EN
    output logic                         olast,
`endif
    input  logic                         ordy
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam int                  CNT_W    = $clog2(TAP_REP + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TAP_REP - 1);
    localparam logic [SEL_BITS-1:0] SEL_MAX  = SEL_BITS'(N_TAPS - 1);

    state_t                  state_q, state_d;
    logic [SEL_BITS-1:0]     ptr_q, ptr_d;
    logic [SEL_BITS-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   odat_q, odat_d;
    logic [SEL_BITS-1:0]     osel_q, osel_d;
    logic                    ovld_q, ovld_d;
`ifdef STREAM_TAP_ARB_LAST_EN
    logic                    olast_q, olast_d;
`endif

    logic                    adv;
    logic                    beat;
    logic                    is_last;
    logic                    cand_vld;
    logic [SEL_BITS-1:0]     cand;
    logic [SEL_BITS-1:0]     src_sel;
    logic [DATA_WIDTH-1:0]   src_dat;
    int                      idx;

    function automatic logic [SEL_BITS-1:0] inc_sel(input logic [SEL_BITS-1:0] s);
        return (s == SEL_MAX) ? '0 : s + 1'b1;
    endfunction

    // Scan from the farthest cyclic offset down so the nearest valid tap to ptr wins.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = 0;
        for (int k = N_TAPS - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_TAPS) idx = idx - N_TAPS;
            if (ivld[idx]) begin
                cand     = SEL_BITS'(idx);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        adv     = !ovld_q || ordy;
        src_sel = (state_q == LOCK) ? grant_q : cand;
        src_dat = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (SEL_BITS'(i) == src_sel) src_dat = idat[i*DATA_WIDTH +: DATA_WIDTH];
        end
        is_last = (TAP_REP == 1) || ((state_q == LOCK) && (cnt_q == CNT_LAST));
    end

    // Output process: only the locked or candidate tap ever sees ready.
    always_comb begin
        irdy = '0;
        if (state_q == LOCK) irdy[grant_q] = adv;
        else if (cand_vld)   irdy[cand]    = adv;
        beat = |(irdy & ivld);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        odat_d  = odat_q;
        osel_d  = osel_q;
        ovld_d  = ovld_q;
`ifdef STREAM_TAP_ARB_LAST_EN
        olast_d = olast_q;
`endif
        if (beat) begin
            odat_d = src_dat;
            osel_d = src_sel;
            ovld_d = 1'b1;
`ifdef STREAM_TAP_ARB_LAST_EN
            olast_d = is_last;
`endif
            if (is_last) begin
                ptr_d   = inc_sel(src_sel);
                cnt_d   = '0;
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                grant_d = src_sel;
                cnt_d   = CNT_W'(1);
                state_d = LOCK;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ordy) begin
            ovld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            odat_q  <= '0;
            osel_q  <= '0;
            ovld_q  <= 1'b0;
`ifdef STREAM_TAP_ARB_LAST_EN
            olast_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            odat_q  <= odat_d;
            osel_q  <= osel_d;
            ovld_q  <= ovld_d;
`ifdef STREAM_TAP_ARB_LAST_EN
            olast_q <= olast_d;
`endif
        end
    end

    assign odat = odat_q;
    assign osel = osel_q;
    assign ovld = ovld_q;
`ifdef STREAM_TAP_ARB_LAST_EN
    assign olast = olast_q;
`endif

endmodule

// File: tb/tb_stream_tap_arb.sv
// Directed bench for stream_tap_arb: several parameterisations driven from one clock and reset.
module tb_stream_tap_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // d1: N_TAPS=4, TAP_REP=3
    logic [31:0] d1_idat;
    logic [3:0]  d1_ivld, d1_irdy;
    logic [7:0]  d1_odat;
    logic [1:0]  d1_osel;
    logic        d1_ovld, d1_ordy, d1_olast;
    // d2: N_TAPS=3, TAP_REP=2
    logic [23:0] d2_idat;
    logic [2:0]  d2_ivld, d2_irdy;
    logic [7:0]  d2_odat;
    logic [1:0]  d2_osel;
    logic        d2_ovld, d2_ordy, d2_olast;
    // d3: N_TAPS=2, TAP_REP=4
    logic [15:0] d3_idat;
    logic [1:0]  d3_ivld, d3_irdy;
    logic [7:0]  d3_odat;
    logic [0:0]  d3_osel;
    logic        d3_ovld, d3_ordy, d3_olast;
    // d5: N_TAPS=2, TAP_REP=1
    logic [15:0] d5_idat;
    logic [1:0]  d5_ivld, d5_irdy;
    logic [7:0]  d5_odat;
    logic [0:0]  d5_osel;
    logic        d5_ovld, d5_ordy, d5_olast;

    stream_tap_arb #(.N_TAPS(4), .DATA_WIDTH(8), .TAP_REP(3)) u_d1 (
        .clk(clk), .rst(rst), .idat(d1_idat), .ivld(d1_ivld), .irdy(d1_irdy),
        .odat(d1_odat), .osel(d1_osel), .ovld(d1_ovld),
`ifdef STREAM_TAP_ARB_LAST_EN
        .olast(d1_olast),
`endif
        .ordy(d1_ordy));

    stream_tap_arb #(.N_TAPS(3), .DATA_WIDTH(8), .TAP_REP(2)) u_d2 (
        .clk(clk), .rst(rst), .idat(d2_idat), .ivld(d2_ivld), .irdy(d2_irdy),
        .odat(d2_odat), .osel(d2_osel), .ovld(d2_ovld),
`ifdef STREAM_TAP_ARB_LAST_EN
        .olast(d2_olast),
`endif
        .ordy(d2_ordy));

    stream_tap_arb #(.N_TAPS(2), .DATA_WIDTH(8), .TAP_REP(4)) u_d3 (
        .clk(clk), .rst(rst), .idat(d3_idat), .ivld(d3_ivld), .irdy(d3_irdy),
        .odat(d3_odat), .osel(d3_osel), .ovld(d3_ovld),
`ifdef STREAM_TAP_ARB_LAST_EN
        .olast(d3_olast),
`endif
        .ordy(d3_ordy));

    stream_tap_arb #(.N_TAPS(2), .DATA_WIDTH(8), .TAP_REP(1)) u_d5 (
        .clk(clk), .rst(rst), .idat(d5_idat), .ivld(d5_ivld), .irdy(d5_irdy),
        .odat(d5_odat), .osel(d5_osel), .ovld(d5_ovld),
`ifdef STREAM_TAP_ARB_LAST_EN
        .olast(d5_olast),
`endif
        .ordy(d5_ordy));

`ifndef STREAM_TAP_ARB_LAST_EN
    assign d1_olast = 1'b0;
    assign d2_olast = 1'b0;
    assign d3_olast = 1'b0;
    assign d5_olast = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d1_idat = '0; d1_ivld = '0; d1_ordy = 1'b1;
        d2_idat = '0; d2_ivld = '0; d2_ordy = 1'b1;
        d3_idat = '0; d3_ivld = '0; d3_ordy = 1'b1;
        d5_idat = '0; d5_ivld = '0; d5_ordy = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (d1_ovld !== 1'b0) begin errors++; $display("[TB] FAIL reset_d1_ovld: got %b expected 0", d1_ovld); end
        checks++; if (d1_osel !== 2'd0) begin errors++; $display("[TB] FAIL reset_d1_osel: got %0d expected 0", d1_osel); end
        checks++; if (d1_irdy !== 4'b0) begin errors++; $display("[TB] FAIL reset_d1_irdy: got %b expected 0000", d1_irdy); end
        checks++; if (d2_ovld !== 1'b0) begin errors++; $display("[TB] FAIL reset_d2_ovld: got %b expected 0", d2_ovld); end
        checks++; if (d2_irdy !== 3'b0) begin errors++; $display("[TB] FAIL reset_d2_irdy: got %b expected 000", d2_irdy); end
        checks++; if (d3_ovld !== 1'b0) begin errors++; $display("[TB] FAIL reset_d3_ovld: got %b expected 0", d3_ovld); end
        checks++; if (d5_ovld !== 1'b0) begin errors++; $display("[TB] FAIL reset_d5_ovld: got %b expected 0", d5_ovld); end
`ifdef STREAM_TAP_ARB_LAST_EN
        checks++; if (d1_olast !== 1'b0) begin errors++; $display("[TB] FAIL reset_d1_olast: got %b expected 0", d1_olast); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_tap();
        do_reset();
        d1_idat = 32'h00A1_0000;
        d1_ivld = 4'b0100;
        #1;
        checks++; if (d1_irdy !== 4'b0100) begin errors++; $display("[TB] FAIL single_irdy: got %b expected 0100", d1_irdy); end
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++; if (d1_ovld !== 1'b1) begin errors++; $display("[TB] FAIL single_ovld beat %0d: got %b expected 1", b, d1_ovld); end
            checks++; if (d1_odat !== 8'hA1) begin errors++; $display("[TB] FAIL single_odat beat %0d: got %h expected a1", b, d1_odat); end
            checks++; if (d1_osel !== 2'd2) begin errors++; $display("[TB] FAIL single_osel beat %0d: got %0d expected 2", b, d1_osel); end
`ifdef STREAM_TAP_ARB_LAST_EN
            checks++; if (d1_olast !== (b == 2)) begin errors++; $display("[TB] FAIL single_olast beat %0d: got %b expected %b", b, d1_olast, (b == 2)); end
`endif
        end
        d1_ivld = 4'b0000;
        tick();
        checks++; if (d1_ovld !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b expected 0", d1_ovld); end
        d1_idat = 32'hD3C2_B1A0;
        d1_ivld = 4'b1111;
        #1;
        checks++; if (d1_irdy !== 4'b1000) begin errors++; $display("[TB] FAIL single_ptr_next: got %b expected 1000", d1_irdy); end
        tick();
        checks++; if (d1_osel !== 2'd3 || d1_odat !== 8'hD3) begin errors++; $display("[TB] FAIL single_next_grant: got sel %0d dat %h expected sel 3 dat d3", d1_osel, d1_odat); end
    endtask

    task automatic test_fairness();
        int seq [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        logic [2:0] exp_rdy;
        do_reset();
        d2_idat = 24'h12_11_10;
        d2_ivld = 3'b111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = '0;
            exp_rdy[seq[k]] = 1'b1;
            checks++; if (d2_irdy !== exp_rdy) begin errors++; $display("[TB] FAIL fair_irdy step %0d: got %b expected %b", k, d2_irdy, exp_rdy); end
            tick();
            checks++; if (d2_ovld !== 1'b1 || d2_osel !== 2'(seq[k])) begin errors++; $display("[TB] FAIL fair_osel step %0d: got vld %b sel %0d expected vld 1 sel %0d", k, d2_ovld, d2_osel, seq[k]); end
            checks++; if (d2_odat !== 8'(8'h10 + seq[k])) begin errors++; $display("[TB] FAIL fair_odat step %0d: got %h expected %h", k, d2_odat, 8'(8'h10 + seq[k])); end
`ifdef STREAM_TAP_ARB_LAST_EN
            checks++; if (d2_olast !== k[0]) begin errors++; $display("[TB] FAIL fair_olast step %0d: got %b expected %b", k, d2_olast, k[0]); end
`endif
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        d2_idat = 24'h00_31_00;
        d2_ivld = 3'b010;
        tick();
        checks++; if (d2_ovld !== 1'b1 || d2_odat !== 8'h31 || d2_osel !== 2'd1) begin errors++; $display("[TB] FAIL bp_first: got vld %b dat %h sel %0d expected 1 31 1", d2_ovld, d2_odat, d2_osel); end
        d2_ordy = 1'b0;
        d2_idat = 24'h00_32_00;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (d2_irdy !== 3'b000) begin errors++; $display("[TB] FAIL bp_irdy cycle %0d: got %b expected 000", c, d2_irdy); end
            tick();
            checks++; if (d2_ovld !== 1'b1 || d2_odat !== 8'h31 || d2_osel !== 2'd1) begin errors++; $display("[TB] FAIL bp_hold cycle %0d: got vld %b dat %h sel %0d expected 1 31 1", c, d2_ovld, d2_odat, d2_osel); end
        end
        d2_ordy = 1'b1;
        #1;
        checks++; if (d2_irdy !== 3'b010) begin errors++; $display("[TB] FAIL bp_release_irdy: got %b expected 010", d2_irdy); end
        tick();
        checks++; if (d2_ovld !== 1'b1 || d2_odat !== 8'h32 || d2_osel !== 2'd1) begin errors++; $display("[TB] FAIL bp_second: got vld %b dat %h sel %0d expected 1 32 1", d2_ovld, d2_odat, d2_osel); end
        d2_ivld = 3'b000;
        tick();
        checks++; if (d2_ovld !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %b expected 0", d2_ovld); end
    endtask

    task automatic test_lock_hold();
        do_reset();
        d3_idat = 16'h77_40;
        d3_ivld = 2'b01;
        tick();
        d3_idat = 16'h77_41;
        tick();
        checks++; if (d3_odat !== 8'h41 || d3_osel !== 1'b0) begin errors++; $display("[TB] FAIL lock_beat2: got dat %h sel %0d expected 41 0", d3_odat, d3_osel); end
        d3_ivld = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (d3_irdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL lock_irdy1 cycle %0d: got %b expected 0", c, d3_irdy[1]); end
            tick();
            checks++; if (d3_ovld !== 1'b0) begin errors++; $display("[TB] FAIL lock_wait_ovld cycle %0d: got %b expected 0", c, d3_ovld); end
        end
        d3_ivld = 2'b11;
        d3_idat = 16'h77_42;
        tick();
        checks++; if (d3_ovld !== 1'b1 || d3_odat !== 8'h42 || d3_osel !== 1'b0) begin errors++; $display("[TB] FAIL lock_beat3: got vld %b dat %h sel %0d expected 1 42 0", d3_ovld, d3_odat, d3_osel); end
        d3_idat = 16'h77_43;
        tick();
        checks++; if (d3_odat !== 8'h43 || d3_osel !== 1'b0) begin errors++; $display("[TB] FAIL lock_beat4: got dat %h sel %0d expected 43 0", d3_odat, d3_osel); end
        #1;
        checks++; if (d3_irdy !== 2'b10) begin errors++; $display("[TB] FAIL lock_handover_irdy: got %b expected 10", d3_irdy); end
        tick();
        checks++; if (d3_ovld !== 1'b1 || d3_odat !== 8'h77 || d3_osel !== 1'b1) begin errors++; $display("[TB] FAIL lock_handover: got vld %b dat %h sel %0d expected 1 77 1", d3_ovld, d3_odat, d3_osel); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        d1_idat = 32'h0000_B100;
        d1_ivld = 4'b0010;
        tick();
        checks++; if (d1_ovld !== 1'b1 || d1_osel !== 2'd1) begin errors++; $display("[TB] FAIL rmid_first: got vld %b sel %0d expected 1 1", d1_ovld, d1_osel); end
        rst = 1'b1;
        d1_ivld = 4'b0000;
        tick();
        checks++; if (d1_ovld !== 1'b0 || d1_irdy !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_cleared: got vld %b irdy %b expected 0 0000", d1_ovld, d1_irdy); end
        rst = 1'b0;
        d1_idat = 32'h04_03_02_01;
        d1_ivld = 4'b1111;
        #1;
        checks++; if (d1_irdy !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_irdy: got %b expected 0001", d1_irdy); end
        tick();
        checks++; if (d1_osel !== 2'd0 || d1_odat !== 8'h01) begin errors++; $display("[TB] FAIL rmid_grant: got sel %0d dat %h expected 0 01", d1_osel, d1_odat); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        d5_idat = 16'hB0_A0;
        d5_ivld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (d5_ovld !== 1'b1 || d5_osel !== k[0]) begin errors++; $display("[TB] FAIL b2b_osel step %0d: got vld %b sel %0d expected 1 %0d", k, d5_ovld, d5_osel, k[0]); end
`ifdef STREAM_TAP_ARB_LAST_EN
            checks++; if (d5_olast !== 1'b1) begin errors++; $display("[TB] FAIL b2b_olast step %0d: got %b expected 1", k, d5_olast); end
`endif
        end
        d5_ivld = 2'b10;
        d5_ordy = 1'b0;
        tick();
        d5_idat = 16'hB1_A0;
        tick();
        checks++; if (d5_ovld !== 1'b1 || d5_odat !== 8'hB0 || d5_osel !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall: got vld %b dat %h sel %0d expected 1 b0 1", d5_ovld, d5_odat, d5_osel); end
        d5_ordy = 1'b1;
        tick();
        checks++; if (d5_ovld !== 1'b1 || d5_odat !== 8'hB1) begin errors++; $display("[TB] FAIL b2b_reload: got vld %b dat %h expected 1 b1", d5_ovld, d5_odat); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_tap();
        test_fairness();
        test_backpressure();
        test_lock_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
